// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard.
// Forwarding select encoding and scoreboard entry field widths.
package hazard_scoreboard_pkg;

  localparam int FWD_RF         = 0;
  localparam int FWD_ENTRY_BASE = 1;

  localparam int SB_VLD_W = 1;
  localparam int SB_LD_W  = 1;

  function automatic int fwd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hs_match_enc.sv
// Per-operand comparator across the scoreboard plus a
// youngest-first priority encoder.
module hs_match_enc
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int IW     = 2
) (
  input  logic [DEPTH-1:0]             vld,
  input  logic [DEPTH-1:0][REG_AW-1:0] regs,
  input  logic [DEPTH-1:0]             ld,
  input  logic [REG_AW-1:0]            src,
  input  logic                         use_src,
  output logic                         hit,
  output logic [IW-1:0]                idx,
  output logic                         ld_at_hit
);

  logic [DEPTH-1:0] m;

  always_comb begin
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = vld[i] && (regs[i] == src)
          && (src != '0) && use_src;
    end
  end

  // Scan oldest to youngest so the youngest match lands last.
  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    ld_at_hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m[i]) begin
        hit       = 1'b1;
        idx       = IW'(i);
        ld_at_hit = ld[i];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight writes EX..WB and derives stall,
// forwarding selects and a saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         id_valid,
  input  logic [REG_AW-1:0]            id_rs,
  input  logic [REG_AW-1:0]            id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic                         id_wr_en,
  input  logic [REG_AW-1:0]            id_wr_reg,
  input  logic                         id_is_load,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rt,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int FW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][SB_VLD_W-1:0] sb_vld;
  logic [DEPTH-1:0][REG_AW-1:0]   sb_reg;
  logic [DEPTH-1:0][SB_LD_W-1:0]  sb_ld;

  logic          hit_rs, hit_rt;
  logic          ld_rs, ld_rt;
  logic [FW-1:0] idx_rs, idx_rt;
  logic          haz;
  logic          load_en;

  hs_match_enc #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .IW     (FW)
  ) u_enc_rs (
    .vld       (sb_vld),
    .regs      (sb_reg),
    .ld        (sb_ld),
    .src       (id_rs),
    .use_src   (id_use_rs),
    .hit       (hit_rs),
    .idx       (idx_rs),
    .ld_at_hit (ld_rs)
  );

  hs_match_enc #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .IW     (FW)
  ) u_enc_rt (
    .vld       (sb_vld),
    .regs      (sb_reg),
    .ld        (sb_ld),
    .src       (id_rt),
    .use_src   (id_use_rt),
    .hit       (hit_rt),
    .idx       (idx_rt),
    .ld_at_hit (ld_rt)
  );

  // With forwarding only a load still sitting in EX
  // has no result available yet.
  always_comb begin
    haz = 1'b0;
    if (FWD_EN != 0) begin
      haz = (hit_rs && idx_rs == '0 && ld_rs)
         || (hit_rt && idx_rt == '0 && ld_rt);
    end else begin
      haz = hit_rs || hit_rt;
    end
    stall = id_valid && !flush && haz;
  end

  always_comb begin
    fwd_rs = FW'(FWD_RF);
    fwd_rt = FW'(FWD_RF);
    if (FWD_EN != 0) begin
      if (hit_rs) fwd_rs = idx_rs + FW'(FWD_ENTRY_BASE);
      if (hit_rt) fwd_rt = idx_rt + FW'(FWD_ENTRY_BASE);
    end
  end

  assign load_en = id_valid && id_wr_en && !stall
                && !flush && (id_wr_reg != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sb_vld    <= '0;
      sb_reg    <= '0;
      sb_ld     <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_reg[i] <= sb_reg[i-1];
        sb_ld[i]  <= sb_ld[i-1];
      end
      sb_vld[0] <= load_en;
      sb_reg[0] <= id_wr_reg;
      sb_ld[0]  <= id_is_load;
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding,
// non-forwarding and narrow-counter configurations.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       id_use_rs, id_use_rt;
  logic       id_wr_en, id_is_load, flush;

  logic        stall_f, stall_n, stall_s;
  logic [1:0]  fwd_rs_f, fwd_rt_f;
  logic [1:0]  fwd_rs_n, fwd_rt_n;
  logic [1:0]  fwd_rs_s, fwd_rt_s;
  logic [15:0] cnt_f, cnt_n;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW (5), .DEPTH (3), .FWD_EN (1), .CNT_W (16)
  ) u_fwd (
    .clk (clk), .reset_n (reset_n),
    .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
    .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .id_wr_en (id_wr_en), .id_wr_reg (id_wr_reg),
    .id_is_load (id_is_load), .flush (flush),
    .stall (stall_f), .fwd_rs (fwd_rs_f), .fwd_rt (fwd_rt_f),
    .stall_cnt (cnt_f)
  );

  hazard_scoreboard #(
    .REG_AW (5), .DEPTH (3), .FWD_EN (0), .CNT_W (16)
  ) u_nof (
    .clk (clk), .reset_n (reset_n),
    .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
    .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .id_wr_en (id_wr_en), .id_wr_reg (id_wr_reg),
    .id_is_load (id_is_load), .flush (flush),
    .stall (stall_n), .fwd_rs (fwd_rs_n), .fwd_rt (fwd_rt_n),
    .stall_cnt (cnt_n)
  );

  hazard_scoreboard #(
    .REG_AW (5), .DEPTH (3), .FWD_EN (0), .CNT_W (2)
  ) u_sat (
    .clk (clk), .reset_n (reset_n),
    .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
    .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .id_wr_en (id_wr_en), .id_wr_reg (id_wr_reg),
    .id_is_load (id_is_load), .flush (flush),
    .stall (stall_s), .fwd_rs (fwd_rs_s), .fwd_rt (fwd_rt_s),
    .stall_cnt (cnt_s)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic v, input int rs, input int rt,
                     input logic urs, input logic urt,
                     input logic we, input int wr,
                     input logic ld, input logic fl);
    id_valid   = v;
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_wr_en   = we;
    id_wr_reg  = 5'(wr);
    id_is_load = ld;
    flush      = fl;
  endtask

  task automatic idle();
    ins(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ins(1'($urandom), int'($urandom_range(31)),
          int'($urandom_range(31)), 1'($urandom),
          1'($urandom), 1'($urandom),
          int'($urandom_range(31)), 1'($urandom),
          1'($urandom));
      tick();
    end
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    #1;

    // reset state
    do_reset();
    settle();
    chk("rst_stall", stall_f, 0);
    chk("rst_fwd_rs", fwd_rs_f, 0);
    chk("rst_fwd_rt", fwd_rt_f, 0);
    chk("rst_cnt", cnt_f, 0);
    tick();

    // load-use with forwarding: lw r8; add r9,r8,r8
    ins(1, 0, 0, 0, 0, 1, 8, 1, 0);
    settle();
    chk("lu_lw_stall", stall_f, 0);
    tick();
    ins(1, 8, 8, 1, 1, 1, 9, 0, 0);
    settle();
    chk("lu_stall1", stall_f, 1);
    tick();
    settle();
    chk("lu_stall2", stall_f, 0);
    chk("lu_fwd_rs", fwd_rs_f, 2);
    chk("lu_fwd_rt", fwd_rt_f, 2);
    chk("lu_cnt", cnt_f, 1);
    tick();

    // ALU chain: add r3; sub r4,r3,r5; and r6,r3,r5
    do_reset();
    ins(1, 1, 2, 1, 1, 1, 3, 0, 0);
    tick();
    ins(1, 3, 5, 1, 1, 1, 4, 0, 0);
    settle();
    chk("alu_stall", stall_f, 0);
    chk("alu_fwd_rs1", fwd_rs_f, 1);
    chk("alu_fwd_rt0", fwd_rt_f, 0);
    tick();
    ins(1, 3, 5, 1, 1, 1, 6, 0, 0);
    settle();
    chk("alu_fwd_rs2", fwd_rs_f, 2);
    chk("alu_fwd_rt2", fwd_rt_f, 0);
    tick();

    // youngest writer wins, unused operand ignored
    do_reset();
    ins(1, 0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    ins(1, 0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    ins(1, 3, 3, 1, 0, 0, 0, 0, 0);
    settle();
    chk("young_fwd_rs", fwd_rs_f, 1);
    chk("unused_fwd_rt", fwd_rt_f, 0);
    tick();

    // no forwarding: ori r7; beq r7,r0 -> 3 stalls
    do_reset();
    ins(1, 0, 0, 1, 0, 1, 7, 0, 0);
    tick();
    ins(1, 7, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("nof_stall%0d", i), stall_n, 1);
      chk($sformatf("nof_fwd%0d", i), fwd_rs_n, 0);
      tick();
    end
    settle();
    chk("nof_release", stall_n, 0);
    chk("nof_cnt", cnt_n, 3);
    tick();

    // writer to r0 never hazards
    do_reset();
    ins(1, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    ins(1, 0, 0, 1, 1, 0, 0, 0, 0);
    settle();
    chk("r0_stall", stall_n, 0);
    tick();
    settle();
    chk("r0_cnt", cnt_n, 0);

    // flush beats hazard: lw r2; add r5,r2 with flush
    do_reset();
    ins(1, 0, 0, 0, 0, 1, 2, 1, 0);
    tick();
    ins(1, 2, 0, 1, 0, 1, 5, 0, 1);
    settle();
    chk("fl_stall", stall_f, 0);
    tick();
    ins(1, 2, 5, 1, 1, 0, 0, 0, 0);
    settle();
    chk("fl_cnt", cnt_f, 0);
    chk("fl_fwd_rs", fwd_rs_f, 2);
    chk("fl_no_entry", fwd_rt_f, 0);
    tick();

    // id_valid low masks a pending load-use
    do_reset();
    ins(1, 0, 0, 0, 0, 1, 2, 1, 0);
    tick();
    ins(0, 2, 0, 1, 0, 1, 5, 0, 0);
    settle();
    chk("inv_stall", stall_f, 0);
    tick();

    // reset mid-stall drops the hazard
    do_reset();
    ins(1, 0, 0, 0, 0, 1, 8, 1, 0);
    tick();
    ins(1, 8, 0, 1, 0, 1, 9, 0, 0);
    settle();
    chk("mid_stall_on", stall_f, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    settle();
    chk("mid_stall_off", stall_f, 0);
    chk("mid_fwd", fwd_rs_f, 0);
    chk("mid_cnt", cnt_f, 0);
    tick();

    // saturation at CNT_W=2: ori r7; add r8,r7 x3; or r9,r8
    do_reset();
    ins(1, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    ins(1, 7, 0, 1, 0, 1, 8, 0, 0);
    tick();
    settle();
    chk("sat_cnt1", cnt_s, 1);
    tick();
    settle();
    chk("sat_cnt2", cnt_s, 2);
    chk("sat_stall", stall_s, 1);
    tick();
    settle();
    chk("sat_enter", stall_s, 0);
    chk("sat_cnt3", cnt_s, 3);
    tick();
    ins(1, 8, 0, 1, 0, 1, 9, 0, 0);
    settle();
    chk("sat_stall2", stall_s, 1);
    tick();
    settle();
    chk("sat_hold", cnt_s, 3);
    chk("wide_cnt", cnt_n, 4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the ID-stage hazard checker. It tracks in-flight register writes in a DEPTH-entry shift scoreboard covering EX through WB. From that state it produces a stall, per-operand forwarding selects and a saturating stall-cycle counter. It sits beside the ID stage and replaces the pipeline-register peeking of the previous unit with its own tracked state, so it needs no hierarchical references.

## Interface
Parameters:
- REG_AW, 5, register-address width; register 0 never creates a hazard.
- DEPTH, 3, tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB); legal range 1..8.
- FWD_EN, 1, 1 = forwarding datapath present (stall only on load-use); 0 = stall on any pending match.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register numbers.
- id_use_rs, id_use_rt  in  1  operand is actually read (decoded from the opcode by the control unit).
- id_wr_en  in  1  instruction writes a register.
- id_wr_reg  in  REG_AW  destination register.
- id_is_load  in  1  instruction is a load.
- flush  in  1  kill the ID instruction this cycle (branch redirect).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_rs, fwd_rt  out  $clog2(DEPTH+1)  0 = register file, k = result of entry k-1.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard entry fields: vld, reg, ld. An entry is a match for a source iff vld, reg == src, reg != 0 and use_src.
- Priority encoder: the lowest-index (youngest) matching entry wins. fwd_x = index+1, or 0 if no match. Both fwd outputs are forced to 0 when FWD_EN=0.
- Stall when id_valid and any of the following:
  - FWD_EN=0: any match on rs or rt in any entry.
  - FWD_EN=1: a match in entry 0 whose ld=1 (load-use). Load results exist only from entry 1 onward.
- flush overrides stall: stall=0 whenever flush=1.
- Shift each cycle: entry[i+1] ← entry[i] for i = 0..DEPTH-2. Entry DEPTH-1 retires.
- Entry 0 load:
  - A real entry {1, id_wr_reg, id_is_load} iff id_valid & id_wr_en & !stall & !flush & id_wr_reg != 0.
  - Otherwise a bubble, vld=0.
  - A stall therefore always inserts exactly one bubble.
- stall_cnt increments by 1 on every cycle with stall=1 and holds at 2^CNT_W−1.
- Register-file write and read in the same cycle is not bypassed. A WB-entry match therefore still counts as a hazard (FWD_EN=0) or as a forward (FWD_EN=1).

## Timing
- stall and fwd_* are combinational from the ID inputs and the registered scoreboard; no added latency.
- Scoreboard and stall_cnt are registered. They update on the clk edge after the cycle's decision.
- Reset (reset_n=0 at an edge):
  - All entries vld=0, stall_cnt=0.
  - Outputs thereafter are stall=0 and fwd_*=0 until an entry is loaded.
  - Reset mid-stall drops all pending hazards in the same edge.
- Load-use with FWD_EN=1 costs exactly 1 stall cycle. The load moves to entry 1 and the dependent then gets fwd=2.
- FWD_EN=0, dependent directly behind a writer: DEPTH stall cycles.
- Simultaneous flush and hazard: no stall, bubble inserted, stall_cnt unchanged.
- id_valid=0: stall=0 and a bubble is inserted.

## Structure
- A shared package/include holds:
  - the scoreboard entry typedef or field-width constants;
  - the fwd encoding constants FWD_RF=0 and FWD_ENTRY_BASE=1.
- One sub-module, hs_match_enc: a DEPTH-wide comparator plus priority encoder. It is instantiated once per source operand and returns hit, index and ld_at_hit.
- Top level: scoreboard shift register, stall logic and counter.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with random inputs → stall=0, fwd_rs=fwd_rt=0, stall_cnt=0 after release.
- FWD_EN=1 load-use:
  - lw r8 then add r9,r8,r8 → stall=1 for exactly 1 cycle;
  - next cycle fwd_rs=fwd_rt=2, stall_cnt=1.
- FWD_EN=1 ALU chain: add r3 then sub r4,r3,r5 → stall=0, fwd_rs=1, fwd_rt=0. With one independent instruction in between, fwd_rs=2.
- FWD_EN=0, DEPTH=3:
  - ori r7 then beq r7,r0 → stall high 3 consecutive cycles, stall_cnt=3;
  - a writer to r0 causes no stall.
- Flush versus hazard: load r2, then a dependent with flush=1 in the same cycle → stall=0, no entry created for it, stall_cnt unchanged.
- Saturation: CNT_W=2 with a sustained FWD_EN=0 hazard chain → stall_cnt reads 1,2,3,3.
